// File: rtl/mem_arb_pkg.sv
// Shared types, limits and width helper for the memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_e;

  localparam int MAX_REQ = 8;
  localparam int MAX_LAT = 4;

  // Never returns less than 1 so single-bit counters/pointers stay legal.
  function automatic int clog2w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_pick.sv
// Combinational winner selection: highest index in fixed mode, or the first
// requester above the pointer (wrapping) in round-robin mode.
module arb_pick #(
  parameter int NUM_REQ = 2,
  parameter int PW      = 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PW-1:0]      ptr_i,
  input  logic               rr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [PW-1:0]      idx_o,
  output logic               any_o
);

  logic found;
  int   j;

  always_comb begin
    idx_o = '0;
    found = 1'b0;
    j     = 0;
    any_o = |req_i;
    if (!rr_i) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_i[i]) idx_o = PW'(i);
      end
    end else begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        j = (int'(ptr_i) + k) % NUM_REQ;
        if (!found && req_i[PW'(j)]) begin
          idx_o = PW'(j);
          found = 1'b1;
        end
      end
    end
    gnt_o = '0;
    if (any_o) gnt_o[idx_o] = 1'b1;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Registered arbiter sharing one fixed-latency memory port between NUM_REQ
// requesters; each access runs ISSUE -> WAIT (MEM_LAT cycles) -> DONE.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int NUM_REQ = 2,
  parameter int MEM_LAT = 1,
  parameter int RR      = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ-1:0]       we,
  input  logic [NUM_REQ*WIDTH-1:0] addr,
  input  logic [NUM_REQ*WIDTH-1:0] wdata,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [NUM_REQ-1:0]       done,
  output logic [WIDTH-1:0]         rdata,
  output logic                     busy,
  output logic                     mem_en,
  output logic                     mem_we,
  output logic [WIDTH-1:0]         mem_addr,
  output logic [WIDTH-1:0]         mem_wdata,
  input  logic [WIDTH-1:0]         mem_rdata,
  output arb_state_e               dbg_state
);

  localparam int PW = clog2w(NUM_REQ);
  localparam int CW = clog2w(MAX_LAT + 1);

  // Handshake: req/we/addr/wdata are a request held stable until the one-cycle
  // gnt pulse; req still high after the gnt cycle is a new request, and only
  // IDLE and DONE sample req. done pulses once per access, rdata valid with it.

  arb_state_e           state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [PW-1:0]        ptr_q, win_q;
  logic                 we_q;
  logic [NUM_REQ-1:0]   gnt_q, done_q;
  logic [WIDTH-1:0]     rdata_q, mem_addr_q, mem_wdata_q;
  logic                 busy_q, mem_en_q, mem_we_q;

  logic [NUM_REQ-1:0]   pick_gnt;
  logic [PW-1:0]        pick_idx;
  logic                 pick_any;
  logic                 take;
  logic                 finish;
  logic [NUM_REQ-1:0]   win_oh;

  arb_pick #(
    .NUM_REQ (NUM_REQ),
    .PW      (PW)
  ) u_pick (
    .req_i (req),
    .ptr_i (ptr_q),
    .rr_i  (RR != 0),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    take    = 1'b0;
    finish  = 1'b0;
    win_oh  = '0;
    win_oh[win_q] = 1'b1;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          take    = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = CW'(1);
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == CW'(MEM_LAT)) begin
          finish  = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (pick_any) begin
          take    = 1'b1;
          state_d = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output flops are loaded from the next-state decision so every port is a
  // register that lines up with the state it describes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ptr_q       <= PW'(NUM_REQ - 1);
      win_q       <= '0;
      we_q        <= 1'b0;
      gnt_q       <= '0;
      done_q      <= '0;
      rdata_q     <= '0;
      busy_q      <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      busy_q   <= (state_d != IDLE);
      gnt_q    <= '0;
      done_q   <= '0;
      mem_en_q <= 1'b0;
      mem_we_q <= 1'b0;
      if (take) begin
        win_q       <= pick_idx;
        ptr_q       <= pick_idx;
        we_q        <= we[pick_idx];
        mem_addr_q  <= addr[int'(pick_idx)*WIDTH +: WIDTH];
        mem_wdata_q <= wdata[int'(pick_idx)*WIDTH +: WIDTH];
        gnt_q       <= pick_gnt;
        mem_en_q    <= 1'b1;
        mem_we_q    <= we[pick_idx];
      end
      if (finish) begin
        done_q <= win_oh;
        if (!we_q) rdata_q <= mem_rdata;
      end
    end
  end

  assign gnt       = gnt_q;
  assign done      = done_q;
  assign rdata     = rdata_q;
  assign busy      = busy_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: three instances (fixed/LAT1, round-robin/LAT1,
// fixed/LAT3) sharing one clock, reset and memory model.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  logic [17:0] exp_a_q[$];
  logic [17:0] exp_c_q[$];
  logic [1:0]  exp_b_q[$];

  // instance a: fixed priority, MEM_LAT=1
  logic [1:0]  req_a = '0, we_a = '0, gnt_a, done_a;
  logic [31:0] addr_a = '0, wdata_a = '0;
  logic [15:0] rdata_a, mem_addr_a, mem_wdata_a, mem_rdata_a;
  logic        busy_a, mem_en_a, mem_we_a;
  arb_state_e  st_a;
  // instance b: round-robin, MEM_LAT=1
  logic [1:0]  req_b = '0, we_b = '0, gnt_b, done_b;
  logic [31:0] addr_b = '0, wdata_b = '0;
  logic [15:0] rdata_b, mem_addr_b, mem_wdata_b, mem_rdata_b;
  logic        busy_b, mem_en_b, mem_we_b;
  arb_state_e  st_b;
  // instance c: fixed priority, MEM_LAT=3
  logic [1:0]  req_c = '0, we_c = '0, gnt_c, done_c;
  logic [31:0] addr_c = '0, wdata_c = '0;
  logic [15:0] rdata_c, mem_addr_c, mem_wdata_c, mem_rdata_c;
  logic        busy_c, mem_en_c, mem_we_c;
  arb_state_e  st_c;

  mem_port_arbiter #(.WIDTH(16), .NUM_REQ(2), .MEM_LAT(1), .RR(0)) u_a (
    .clk(clk), .rst_n(rst_n), .req(req_a), .we(we_a), .addr(addr_a), .wdata(wdata_a),
    .gnt(gnt_a), .done(done_a), .rdata(rdata_a), .busy(busy_a), .mem_en(mem_en_a),
    .mem_we(mem_we_a), .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a),
    .mem_rdata(mem_rdata_a), .dbg_state(st_a));
  mem_port_arbiter #(.WIDTH(16), .NUM_REQ(2), .MEM_LAT(1), .RR(1)) u_b (
    .clk(clk), .rst_n(rst_n), .req(req_b), .we(we_b), .addr(addr_b), .wdata(wdata_b),
    .gnt(gnt_b), .done(done_b), .rdata(rdata_b), .busy(busy_b), .mem_en(mem_en_b),
    .mem_we(mem_we_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
    .mem_rdata(mem_rdata_b), .dbg_state(st_b));
  mem_port_arbiter #(.WIDTH(16), .NUM_REQ(2), .MEM_LAT(3), .RR(0)) u_c (
    .clk(clk), .rst_n(rst_n), .req(req_c), .we(we_c), .addr(addr_c), .wdata(wdata_c),
    .gnt(gnt_c), .done(done_c), .rdata(rdata_c), .busy(busy_c), .mem_en(mem_en_c),
    .mem_we(mem_we_c), .mem_addr(mem_addr_c), .mem_wdata(mem_wdata_c),
    .mem_rdata(mem_rdata_c), .dbg_state(st_c));

  // Memory: fixed contents plus one writable location; 0xDEAD outside the valid cycle.
  logic        wr_vld = 1'b0;
  logic [15:0] wr_addr = '0, wr_data = '0;
  logic [15:0] rd_a = 16'hDEAD, rd_b = 16'hDEAD;
  logic [15:0] rd_c1 = 16'hDEAD, rd_c2 = 16'hDEAD, rd_c3 = 16'hDEAD;

  function automatic logic [15:0] mem_base(input logic [15:0] a);
    return (a == 16'h0010) ? 16'hBEEF : (a ^ 16'h5A5A);
  endfunction

  function automatic logic [15:0] mem_rd(input logic [15:0] a, input logic v,
                                         input logic [15:0] wa, input logic [15:0] wd);
    return (v && wa == a) ? wd : mem_base(a);
  endfunction

  always @(posedge clk) begin
    if (mem_en_a && mem_we_a) begin
      wr_vld  <= 1'b1;
      wr_addr <= mem_addr_a;
      wr_data <= mem_wdata_a;
    end
    rd_a  <= (mem_en_a && !mem_we_a) ? mem_rd(mem_addr_a, wr_vld, wr_addr, wr_data) : 16'hDEAD;
    rd_b  <= (mem_en_b && !mem_we_b) ? mem_base(mem_addr_b) : 16'hDEAD;
    rd_c1 <= (mem_en_c && !mem_we_c) ? mem_base(mem_addr_c) : 16'hDEAD;
    rd_c2 <= rd_c1;
    rd_c3 <= rd_c2;
  end
  assign mem_rdata_a = rd_a;
  assign mem_rdata_b = rd_b;
  assign mem_rdata_c = rd_c3;

  // Scoreboards for completions of instances a and c.
  always @(negedge clk) begin
    logic [17:0] e;
    if (rst_n && done_a != 2'b00) begin
      n_total++;
      if (exp_a_q.size() == 0) begin
        $display("FAIL sb_a unexpected done=%b rdata=%h", done_a, rdata_a);
      end else begin
        e = exp_a_q.pop_front();
        if ({done_a, rdata_a} !== e)
          $display("FAIL sb_a got done=%b rdata=%h exp done=%b rdata=%h",
                   done_a, rdata_a, e[17:16], e[15:0]);
        else n_pass++;
      end
    end
    if (rst_n && done_c != 2'b00) begin
      n_total++;
      if (exp_c_q.size() == 0) begin
        $display("FAIL sb_c unexpected done=%b rdata=%h", done_c, rdata_c);
      end else begin
        e = exp_c_q.pop_front();
        if ({done_c, rdata_c} !== e)
          $display("FAIL sb_c got done=%b rdata=%h exp done=%b rdata=%h",
                   done_c, rdata_c, e[17:16], e[15:0]);
        else n_pass++;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [54:0] z;
    repeat (2) cyc();
    z = {gnt_a, done_a, rdata_a, busy_a, mem_en_a, mem_we_a, mem_addr_a, mem_wdata_a};
    n_total++;
    if (z !== '0 || st_a !== IDLE) $display("FAIL reset_a got=%h st=%0d exp=0", z, st_a);
    else n_pass++;
    z = {gnt_b, done_b, rdata_b, busy_b, mem_en_b, mem_we_b, mem_addr_b, mem_wdata_b};
    n_total++;
    if (z !== '0 || st_b !== IDLE) $display("FAIL reset_b got=%h st=%0d exp=0", z, st_b);
    else n_pass++;
    z = {gnt_c, done_c, rdata_c, busy_c, mem_en_c, mem_we_c, mem_addr_c, mem_wdata_c};
    n_total++;
    if (z !== '0 || st_c !== IDLE) $display("FAIL reset_c got=%h st=%0d exp=0", z, st_c);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_read();
    req_a = 2'b01; we_a = 2'b00; addr_a[15:0] = 16'h0010;
    exp_a_q.push_back({2'b01, 16'hBEEF});
    cyc();
    n_total++;
    if ({gnt_a, mem_en_a, mem_we_a, mem_addr_a, busy_a} !== {2'b01, 1'b1, 1'b0, 16'h0010, 1'b1})
      $display("FAIL read_issue gnt=%b en=%b we=%b addr=%h busy=%b exp 01/1/0/0010/1",
               gnt_a, mem_en_a, mem_we_a, mem_addr_a, busy_a);
    else n_pass++;
    req_a = 2'b00;
    cyc();
    n_total++;
    if ({gnt_a, mem_en_a, done_a, busy_a} !== {2'b00, 1'b0, 2'b00, 1'b1})
      $display("FAIL read_wait gnt=%b en=%b done=%b busy=%b exp 00/0/00/1",
               gnt_a, mem_en_a, done_a, busy_a);
    else n_pass++;
    cyc();
    n_total++;
    if ({done_a, rdata_a, busy_a} !== {2'b01, 16'hBEEF, 1'b1})
      $display("FAIL read_done done=%b rdata=%h busy=%b exp 01/BEEF/1", done_a, rdata_a, busy_a);
    else n_pass++;
    cyc();
    n_total++;
    if ({done_a, busy_a, rdata_a} !== {2'b00, 1'b0, 16'hBEEF})
      $display("FAIL read_idle done=%b busy=%b rdata=%h exp 00/0/BEEF", done_a, busy_a, rdata_a);
    else n_pass++;
  endtask

  task automatic test_fixed_priority();
    req_a = 2'b11; we_a = 2'b00; addr_a = {16'h8000, 16'h0020};
    exp_a_q.push_back({2'b10, 16'h8000 ^ 16'h5A5A});
    exp_a_q.push_back({2'b01, 16'h0020 ^ 16'h5A5A});
    cyc();
    n_total++;
    if ({gnt_a, mem_addr_a} !== {2'b10, 16'h8000})
      $display("FAIL prio_first gnt=%b addr=%h exp 10/8000", gnt_a, mem_addr_a);
    else n_pass++;
    req_a = 2'b01;
    cyc();
    cyc();
    n_total++;
    if (done_a !== 2'b10) $display("FAIL prio_done1 done=%b exp 10", done_a);
    else n_pass++;
    cyc();
    n_total++;
    if ({gnt_a, mem_en_a, mem_addr_a, busy_a} !== {2'b01, 1'b1, 16'h0020, 1'b1})
      $display("FAIL prio_b2b gnt=%b en=%b addr=%h busy=%b exp 01/1/0020/1",
               gnt_a, mem_en_a, mem_addr_a, busy_a);
    else n_pass++;
    req_a = 2'b00;
    cyc();
    cyc();
    n_total++;
    if (done_a !== 2'b01) $display("FAIL prio_done0 done=%b exp 01", done_a);
    else n_pass++;
    cyc();
  endtask

  task automatic test_write();
    logic [15:0] prior;
    prior = 16'h0020 ^ 16'h5A5A;
    req_a = 2'b10; we_a = 2'b10; addr_a = {16'h0100, 16'h0000}; wdata_a = {16'h1234, 16'h0000};
    exp_a_q.push_back({2'b10, prior});
    cyc();
    n_total++;
    if ({gnt_a, mem_en_a, mem_we_a, mem_addr_a, mem_wdata_a} !== {2'b10, 1'b1, 1'b1, 16'h0100, 16'h1234})
      $display("FAIL write_issue gnt=%b en=%b we=%b addr=%h wd=%h exp 10/1/1/0100/1234",
               gnt_a, mem_en_a, mem_we_a, mem_addr_a, mem_wdata_a);
    else n_pass++;
    req_a = 2'b00; we_a = 2'b00;
    cyc();
    n_total++;
    if ({mem_en_a, mem_we_a} !== 2'b00) $display("FAIL write_wait en=%b we=%b exp 0/0", mem_en_a, mem_we_a);
    else n_pass++;
    cyc();
    n_total++;
    if ({done_a, rdata_a} !== {2'b10, prior})
      $display("FAIL write_done done=%b rdata=%h exp 10/%h", done_a, rdata_a, prior);
    else n_pass++;
    cyc();
    req_a = 2'b01; addr_a = {16'h0000, 16'h0100};
    exp_a_q.push_back({2'b01, 16'h1234});
    cyc();
    n_total++;
    if ({gnt_a, mem_we_a} !== {2'b01, 1'b0}) $display("FAIL readback_issue gnt=%b we=%b exp 01/0", gnt_a, mem_we_a);
    else n_pass++;
    req_a = 2'b00;
    repeat (3) cyc();
  endtask

  task automatic test_reset_mid();
    logic [54:0] z;
    req_a = 2'b01; we_a = 2'b00; addr_a = {16'h0000, 16'h0030};
    cyc();
    cyc();
    #2;
    rst_n = 1'b0;
    #1;
    z = {gnt_a, done_a, rdata_a, busy_a, mem_en_a, mem_we_a, mem_addr_a, mem_wdata_a};
    n_total++;
    if (z !== '0 || st_a !== IDLE) $display("FAIL reset_mid got=%h st=%0d exp=0", z, st_a);
    else n_pass++;
    @(posedge clk);
    #3;
    exp_a_q.push_back({2'b01, 16'h0030 ^ 16'h5A5A});
    rst_n = 1'b1;
    cyc();
    n_total++;
    if ({gnt_a, mem_en_a, mem_addr_a} !== {2'b01, 1'b1, 16'h0030})
      $display("FAIL reset_reissue gnt=%b en=%b addr=%h exp 01/1/0030", gnt_a, mem_en_a, mem_addr_a);
    else n_pass++;
    req_a = 2'b00;
    cyc();
    cyc();
    n_total++;
    if (done_a !== 2'b01) $display("FAIL reset_done done=%b exp 01", done_a);
    else n_pass++;
    cyc();
  endtask

  task automatic test_round_robin();
    int ngrant;
    logic [1:0] e;
    ngrant = 0;
    for (int i = 0; i < 6; i++) exp_b_q.push_back((i % 2 == 0) ? 2'b01 : 2'b10);
    addr_b = {16'h0050, 16'h0040};
    req_b = 2'b11;
    for (int t = 0; t < 60; t++) begin
      cyc();
      n_total++;
      if ($countones(gnt_b) > 1 || $countones(done_b) > 1)
        $display("FAIL rr_onehot gnt=%b done=%b exp at most one hot", gnt_b, done_b);
      else n_pass++;
      if (gnt_b != 2'b00) begin
        n_total++;
        if (exp_b_q.size() == 0) begin
          $display("FAIL rr_order extra gnt=%b", gnt_b);
        end else begin
          e = exp_b_q.pop_front();
          if (gnt_b !== e) $display("FAIL rr_order grant %0d gnt=%b exp %b", ngrant, gnt_b, e);
          else n_pass++;
        end
        ngrant++;
        if (ngrant == 6) req_b = 2'b00;
      end
      if (ngrant >= 6 && !busy_b) break;
    end
    n_total++;
    if (ngrant != 6 || busy_b !== 1'b0) $display("FAIL rr_count grants=%0d busy=%b exp 6/0", ngrant, busy_b);
    else n_pass++;
    n_total++;
    if (rdata_b !== (16'h0050 ^ 16'h5A5A)) $display("FAIL rr_rdata got=%h exp=%h", rdata_b, 16'h0050 ^ 16'h5A5A);
    else n_pass++;
  endtask

  task automatic test_latency3();
    req_c = 2'b01; we_c = 2'b00; addr_c = {16'h0000, 16'h0010};
    exp_c_q.push_back({2'b01, 16'hBEEF});
    cyc();
    n_total++;
    if ({gnt_c, mem_en_c, mem_addr_c} !== {2'b01, 1'b1, 16'h0010})
      $display("FAIL lat3_issue gnt=%b en=%b addr=%h exp 01/1/0010", gnt_c, mem_en_c, mem_addr_c);
    else n_pass++;
    req_c = 2'b00;
    for (int k = 2; k <= 4; k++) begin
      cyc();
      n_total++;
      if ({done_c, mem_en_c, busy_c} !== {2'b00, 1'b0, 1'b1})
        $display("FAIL lat3_wait cycle %0d done=%b en=%b busy=%b exp 00/0/1", k, done_c, mem_en_c, busy_c);
      else n_pass++;
    end
    cyc();
    n_total++;
    if ({done_c, rdata_c} !== {2'b01, 16'hBEEF})
      $display("FAIL lat3_done done=%b rdata=%h exp 01/BEEF", done_c, rdata_c);
    else n_pass++;
    cyc();
    n_total++;
    if (busy_c !== 1'b0) $display("FAIL lat3_idle busy=%b exp 0", busy_c);
    else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_read();
    test_fixed_priority();
    test_write();
    test_reset_mid();
    test_round_robin();
    test_latency3();
    repeat (3) cyc();
    n_total++;
    if (exp_a_q.size() != 0 || exp_c_q.size() != 0 || exp_b_q.size() != 0)
      $display("FAIL sb_drain left a=%0d b=%0d c=%0d exp 0", exp_a_q.size(), exp_b_q.size(), exp_c_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
